// File: rtl/nt_misr_window_monitor_if.sv
// Bus bundle for nt_misr_window_monitor: stimulus/golden inputs and run status outputs.
// The master drives stimulus; the slave (the monitor) returns status and signature.
interface nt_misr_window_monitor_if #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16
);
  localparam int CNT_W = $clog2(WINDOW + 1);

  logic             start;
  logic             stim_valid;
  logic [WIDTH-1:0] node_in;
  logic [WIDTH-1:0] golden;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    output start, stim_valid, node_in, golden,
    input  busy, done, mismatch, signature, sample_cnt
  );

  modport slave (
    input  start, stim_valid, node_in, golden,
    output busy, done, mismatch, signature, sample_cnt
  );
endinterface

// File: rtl/nt_misr_window_monitor.sv
// MISR-based window monitor: compresses WINDOW accepted node samples into a signature
// and compares it with a golden value, flagging divergence in a sticky mismatch bit.
module nt_misr_window_monitor #(
  parameter int               WIDTH  = 8,
  parameter int               WINDOW = 16,
  parameter logic [WIDTH-1:0] POLY   = 8'h1D,
  parameter logic [WIDTH-1:0] SEED   = '0
) (
  input logic                     I1294_clk,
  input logic                     I1301_rst,
  nt_misr_window_monitor_if.slave bus
);

  localparam int               CNT_W    = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             mis_q;

  // One MISR step: shift left, fold the outgoing MSB back through POLY, absorb the sample.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] fb;
    fb = sig[WIDTH-1] ? POLY : {WIDTH{1'b0}};
    return {sig[WIDTH-2:0], 1'b0} ^ fb ^ din;
  endfunction

  assign sig_d = misr_step(sig_q, bus.node_in);
  assign cnt_d = cnt_q + CNT_ONE;

  // Run controller: IDLE waits for start, RUN absorbs valid samples, CHECK grades the run.
  always_ff @(posedge I1294_clk) begin
    if (I1301_rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // stim_valid is deliberately not looked at here, even alongside start.
          if (bus.start) begin
            state_q <= RUN;
            sig_q   <= SEED;
            cnt_q   <= {CNT_W{1'b0}};
            mis_q   <= 1'b0;
          end
        end
        RUN: begin
          if (bus.stim_valid) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (cnt_q == LAST_CNT) begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          mis_q   <= (sig_q != bus.golden);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.mismatch   = mis_q;
  assign bus.signature  = sig_q;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: doc/nt_misr_window_monitor.md
Name: nt_misr_window_monitor

Overview:
- Parametrised successor to the fixed Nt-node subcircuits used in the trojan-detection benchmarks. The earlier subcircuits each fed a single net into a flop-and-gate cone.
- Compresses WIDTH observed node outputs into a multiple-input signature register (MISR) over a programmable window of accepted samples, then compares the result against a golden signature.
- Sits beside each benchmark subcircuit under test and flags any signature divergence caused by a trigger or payload.

Parameters:
- WIDTH, 8, number of observed node channels; also the signature width (>=2).
- WINDOW, 16, number of accepted samples per run (>=1).
- POLY, 8'h1D, MISR feedback polynomial taps, WIDTH bits.
- SEED, 0, signature value loaded on reset and on each start.

Ports:
- I1294_clk  in  1  single clock; all state updates on the rising edge.
- I1301_rst  in  1  reset, synchronous and active-high.
- start  in  1  begins a run; honoured only in IDLE.
- stim_valid  in  1  node_in holds a sample this cycle; sampled only in RUN.
- node_in  in  WIDTH  observed node values.
- golden  in  WIDTH  expected signature; sampled in CHECK.
- busy  out  1  high in RUN and CHECK.
- done  out  1  one-cycle pulse when a run finishes.
- mismatch  out  1  sticky result of the last run.
- signature  out  WIDTH  current MISR contents.
- sample_cnt  out  $clog2(WINDOW+1)  samples accepted in the current run.

Behaviour:
- Reset, when I1301_rst=1 at an edge:
  - state=IDLE, signature=SEED, sample_cnt=0, done=0, mismatch=0, busy=0.
  - Reset overrides every other input, including mid-run; a run interrupted this way is discarded with no done pulse.
- FSM states: IDLE, RUN, CHECK.
  - IDLE: on start=1 -> RUN; signature<=SEED, sample_cnt<=0, mismatch<=0. stim_valid is ignored in IDLE, even in the same cycle as start, so the first sample can arrive in the cycle after start.
  - RUN: when stim_valid=1, signature <= ({signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0)) ^ node_in, and sample_cnt increments.
  - RUN, stim_valid=0: signature and count hold (stall, no timeout).
  - RUN exit: the edge that absorbs the WINDOW-th sample moves the FSM to CHECK.
  - CHECK, one cycle: at its closing edge, mismatch <= (signature != golden), done<=1 for exactly one cycle, state -> IDLE.
- start asserted in RUN or CHECK is ignored, not queued.
- Latency: done rises at the second edge after the cycle carrying the WINDOW-th valid sample, i.e. one CHECK cycle.
- Outputs after a run:
  - signature holds the final value until the next start or reset.
  - mismatch holds until the next start or reset.
  - sample_cnt holds WINDOW until the next start.
- busy is combinational from state: (state != IDLE).
- All arithmetic is modulo 2^WIDTH; sample_cnt never exceeds WINDOW.
- WINDOW=1: a single valid sample -> CHECK -> done; no special casing.

Test Plan:
- WIDTH=8, WINDOW=4, SEED=0; start, then node_in=01,02,04,08 with stim_valid=1 back-to-back; golden=00 -> signature 01,00,04,00; done pulses two edges after the last sample; mismatch=0; sample_cnt=4.
- WINDOW=2, node_in=FF,FF; golden=1C -> signature FF then 1C; mismatch=0. Repeat with golden=1D -> mismatch=1, held through 10 idle cycles.
- Stall: WINDOW=4 samples interleaved with stim_valid=0 gaps of 3 cycles -> same signature as the back-to-back case; busy stays high throughout; done occurs exactly once.
- start together with stim_valid=1, node_in=AA in IDLE -> AA not absorbed, sample_cnt=0 after the edge. A start pulse mid-RUN -> no restart; the count continues.
- I1301_rst=1 for one cycle after 2 of 4 samples -> next edge shows state IDLE, signature=00, sample_cnt=0, busy=0, no done pulse. A fresh start then completes normally.
- Back-to-back runs: start on the cycle after done -> mismatch from the prior run clears to 0 at that edge; the second run's signature starts from SEED.
